sobel_window_gen: RTL and testbench



---
 rtl/sobel_pkg.sv | 18 +
 rtl/sobel_line_buf.sv | 27 ++
 rtl/sobel_window_gen.sv | 158 +++++++++++++++
 tb/tb_sobel_window_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel 3x3 window generator.
package sobel_pkg;

  localparam int DefPixelWidth  = 8;
  localparam int DefMaxWidth    = 256;
  localparam int DefDimWidth    = 16;
  localparam int SobelWinPixels = 9;

  // Entry 3*r+c holds row r (0 = top), column c (0 = left).
  typedef logic [SobelWinPixels-1:0][DefPixelWidth-1:0] sobel_win_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } sobel_state_e;

endpackage

// File: rtl/sobel_line_buf.sv
// One image row of pixel storage: combinational read, synchronous write.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int PixelWidth = DefPixelWidth,
  parameter int Depth      = DefMaxWidth,
  parameter int AddrW      = $clog2(Depth)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AddrW-1:0]      addr_i,
  input  logic [PixelWidth-1:0] wdata_i,
  output logic [PixelWidth-1:0] rdata_o
);

  logic [PixelWidth-1:0] mem_q [Depth];

  // Read returns the old entry when a write to the same address lands this cycle.
  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Turns a raster pixel stream into 3x3 windows for every interior pixel of a frame.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int PixelWidth = DefPixelWidth,
  parameter int MaxWidth   = DefMaxWidth,
  parameter int DimWidth   = DefDimWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                start_i,
  input  logic [DimWidth-1:0]                 cfg_width_i,
  input  logic [DimWidth-1:0]                 cfg_height_i,
  input  logic                                pix_valid_i,
  output logic                                pix_ready_o,
  input  logic [PixelWidth-1:0]               pix_data_i,
  output logic                                win_valid_o,
  input  logic                                win_ready_i,
  output logic [SobelWinPixels*PixelWidth-1:0] win_data_o,
  output logic [DimWidth-1:0]                 win_x_o,
  output logic [DimWidth-1:0]                 win_y_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                cfg_err_o
);

  localparam int AddrW = $clog2(MaxWidth);

  sobel_state_e state_q;
  logic [DimWidth-1:0] w_q, h_q, x_q, y_q, win_x_q, win_y_q;
  logic win_valid_q, done_q, cfg_err_q;
  logic [SobelWinPixels-1:0][PixelWidth-1:0] win_q, win_d;
  logic [PixelWidth-1:0] top_pix, mid_pix;
  logic [AddrW-1:0] addr;
  logic accept, cfg_ok, x_last, y_last, emit;

  assign cfg_ok = (cfg_width_i >= DimWidth'(3)) &&
                  (cfg_width_i <= DimWidth'(MaxWidth)) &&
                  (cfg_height_i >= DimWidth'(3));

  assign pix_ready_o = (state_q == StRun) && (!win_valid_q || win_ready_i);
  assign accept      = pix_valid_i && pix_ready_o;
  assign x_last      = (x_q == w_q - DimWidth'(1));
  assign y_last      = (y_q == h_q - DimWidth'(1));
  // Columns left over from the previous row are flushed by the time x reaches 2.
  assign emit        = (x_q >= DimWidth'(2)) && (y_q >= DimWidth'(2));
  assign addr        = x_q[AddrW-1:0];

  // lb0 holds the row above the current one, lb1 the row above that.
  sobel_line_buf #(
    .PixelWidth(PixelWidth),
    .Depth     (MaxWidth)
  ) u_lb0 (
    .clk_i  (clk_i),
    .we_i   (accept),
    .addr_i (addr),
    .wdata_i(pix_data_i),
    .rdata_o(mid_pix)
  );

  sobel_line_buf #(
    .PixelWidth(PixelWidth),
    .Depth     (MaxWidth)
  ) u_lb1 (
    .clk_i  (clk_i),
    .we_i   (accept),
    .addr_i (addr),
    .wdata_i(mid_pix),
    .rdata_o(top_pix)
  );

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]   = win_q[3*r+1];
      win_d[3*r+1] = win_q[3*r+2];
    end
    win_d[2] = top_pix;
    win_d[5] = mid_pix;
    win_d[8] = pix_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      w_q         <= '0;
      h_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      win_valid_q <= 1'b0;
      win_q       <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;

      // The window only shifts on accept, and accept implies the slot is free.
      if (accept) begin
        win_q <= win_d;
      end
      if (accept && emit) begin
        win_valid_q <= 1'b1;
        win_x_q     <= x_q - DimWidth'(1);
        win_y_q     <= y_q - DimWidth'(1);
      end else if (win_ready_i) begin
        win_valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (cfg_ok) begin
              w_q     <= cfg_width_i;
              h_q     <= cfg_height_i;
              x_q     <= '0;
              y_q     <= '0;
              state_q <= StRun;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (accept) begin
            if (x_last) begin
              x_q <= '0;
              y_q <= y_q + DimWidth'(1);
            end else begin
              x_q <= x_q + DimWidth'(1);
            end
            if (x_last && y_last) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (!win_valid_q || win_ready_i) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign win_valid_o = win_valid_q;
  assign win_data_o  = win_q;
  assign win_x_o     = win_x_q;
  assign win_y_o     = win_y_q;
  assign busy_o      = (state_q == StRun) || (state_q == StDrain);
  assign done_o      = done_q;
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen with a golden-model window scoreboard.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int PW = 8;
  localparam int MW = 256;
  localparam int DW = 16;

  typedef struct packed {
    sobel_win_t    win;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            start_i;
  logic [DW-1:0]   cfg_width_i, cfg_height_i;
  logic            pix_valid_i, pix_ready_o;
  logic [PW-1:0]   pix_data_i;
  logic            win_valid_o, win_ready_i;
  logic [9*PW-1:0] win_data_o;
  logic [DW-1:0]   win_x_o, win_y_o;
  logic            busy_o, done_o, cfg_err_o;

  always #5 clk = ~clk;

  sobel_window_gen #(.PixelWidth(PW), .MaxWidth(MW), .DimWidth(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .cfg_width_i (cfg_width_i),
    .cfg_height_i(cfg_height_i),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .pix_data_i  (pix_data_i),
    .win_valid_o (win_valid_o),
    .win_ready_i (win_ready_i),
    .win_data_o  (win_data_o),
    .win_x_o     (win_x_o),
    .win_y_o     (win_y_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .cfg_err_o   (cfg_err_o)
  );

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  int px, py, cur_w, cur_h, pat, mode, cyc;
  int win_cnt, done_cnt, err_cnt;
  bit prev_hs, stalled, have_first, busy_seen, pr_seen;
  logic [127:0] stall_snap;
  logic [9*PW-1:0] first_win;
  logic [DW-1:0] last_x, last_y;

  function automatic logic [7:0] pix_val(int p, int x, int y);
    case (p)
      0:       return 8'(16 * y + x);
      1:       return 8'(y * cur_w + x + 1);
      2:       return 8'(x + 3 * y);
      default: return 8'(x * 37 + y * 101 + 5);
    endcase
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample everything at the falling edge, then return just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (busy_o) busy_seen = 1;
    if (pix_ready_o) pr_seen = 1;
    if (cfg_err_o) err_cnt++;
    if (done_o) begin
      done_cnt++;
      check("done_busy_low", 128'(busy_o), 128'(0));
      check("done_after_hs", 128'(prev_hs), 128'(1));
      check("done_win_count", 128'(win_cnt), 128'((cur_w - 2) * (cur_h - 2)));
    end
    if (win_valid_o && !win_ready_i) begin
      check("stall_pix_ready", 128'(pix_ready_o), 128'(0));
      if (stalled) check("stall_hold", {win_x_o, win_y_o, win_data_o}, stall_snap);
      stalled = 1;
      stall_snap = {win_x_o, win_y_o, win_data_o};
    end else begin
      stalled = 0;
    end
    prev_hs = win_valid_o && win_ready_i;
    if (prev_hs) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_extra_window observed=(%0d,%0d) expected=none", win_x_o, win_y_o);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("win_data", 128'(win_data_o), 128'(e.win));
        check("win_xy", {win_x_o, win_y_o}, {e.x, e.y});
      end
      win_cnt++;
      if (!have_first) begin
        have_first = 1;
        first_win = win_data_o;
      end
      last_x = win_x_o;
      last_y = win_y_o;
    end
    if (pix_valid_i && pix_ready_o) begin
      if (px >= 2 && py >= 2) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.win[3*r+c] = pix_val(pat, px - 2 + c, py - 2 + r);
        e.x = DW'(px - 1);
        e.y = DW'(py - 1);
        sb.push_back(e);
      end
      if (px == cur_w - 1) begin
        px = 0;
        py++;
      end else begin
        px++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(int w, int h, int p, int m);
    cur_w = w; cur_h = h; pat = p; mode = m;
    px = 0; py = 0; win_cnt = 0; done_cnt = 0; have_first = 0;
    stalled = 0; prev_hs = 0;
    sb.delete();
    cfg_width_i = DW'(w);
    cfg_height_i = DW'(h);
    start_i = 1;
    pix_valid_i = 0;
    win_ready_i = 1;
    cycle();
    start_i = 0;
    check("busy_after_start", 128'(busy_o), 128'(1));
  endtask

  task automatic feed_one();
    pix_valid_i = (py < cur_h);
    pix_data_i = pix_val(pat, px, py);
    win_ready_i = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    cycle();
  endtask

  task automatic run_frame(int w, int h, int p, int m);
    start_frame(w, h, p, m);
    for (int n = 0; n < 20000 && done_cnt == 0; n++) feed_one();
    pix_valid_i = 0;
    win_ready_i = 1;
    check("frame_done_seen", 128'(done_cnt), 128'(1));
    check("frame_win_total", 128'(win_cnt), 128'((w - 2) * (h - 2)));
    check("frame_sb_drained", 128'(sb.size()), 128'(0));
    check("frame_busy_end", 128'(busy_o), 128'(0));
    for (int n = 0; n < 3; n++) cycle();
    check("frame_single_done", 128'(done_cnt), 128'(1));
  endtask

  task automatic check_zero(string tag);
    check(tag, {win_valid_o, pix_ready_o, busy_o, done_o, cfg_err_o, win_x_o, win_y_o, win_data_o},
          128'(0));
  endtask

  initial begin
    rst_ni = 0; start_i = 0; cfg_width_i = '0; cfg_height_i = '0;
    pix_valid_i = 0; pix_data_i = '0; win_ready_i = 1; cyc = 0;
    err_cnt = 0; busy_seen = 0; pr_seen = 0;
    #12;
    check_zero("reset_outputs");
    @(negedge clk);
    rst_ni = 1;
    @(posedge clk);
    #1;

    // 4x4, pixel = 16y+x, always ready.
    run_frame(4, 4, 0, 0);
    check("first_win_4x4", 128'(first_win), 128'(72'h222120121110020100));

    // Minimum 3x3 frame, pixels 1..9.
    run_frame(3, 3, 1, 0);
    check("win_3x3", 128'(first_win), 128'(72'h090807060504030201));
    check("xy_3x3", {last_x, last_y}, {16'd1, 16'd1});

    // 5x4 under backpressure.
    run_frame(5, 4, 3, 1);

    // Invalid configurations.
    err_cnt = 0; busy_seen = 0; pr_seen = 0;
    cfg_width_i = 16'd2; cfg_height_i = 16'd4; start_i = 1;
    cycle();
    start_i = 0;
    cycle(); cycle();
    check("cfg_err_w2", 128'(err_cnt), 128'(1));
    cfg_width_i = DW'(MW + 1); cfg_height_i = 16'd4; start_i = 1;
    cycle();
    start_i = 0;
    cycle(); cycle();
    check("cfg_err_wmax1", 128'(err_cnt), 128'(2));
    check("cfg_err_busy", 128'(busy_seen), 128'(0));
    check("cfg_err_pix_ready", 128'(pr_seen), 128'(0));

    // Full-width frame exercises the whole line buffer.
    run_frame(MW, 3, 2, 0);
    check("wide_last_xy", {last_x, last_y}, {16'(MW - 2), 16'd1});

    // Reset in the middle of a frame, then a fresh frame.
    start_frame(4, 4, 0, 0);
    for (int n = 0; n < 6; n++) feed_one();
    pix_valid_i = 0;
    rst_ni = 0;
    #2;
    check_zero("midframe_reset_outputs");
    for (int n = 0; n < 3; n++) cycle();
    check_zero("reset_held_outputs");
    check("reset_no_done", 128'(done_cnt), 128'(0));
    @(negedge clk);
    rst_ni = 1;
    @(posedge clk);
    #1;
    check("post_reset_idle", 128'(busy_o), 128'(0));
    run_frame(4, 4, 0, 0);
    check("post_reset_first_win", 128'(first_win), 128'(72'h222120121110020100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
